// File: rtl/mmio_uart_tx.sv
// ---------------------------------------------------------------------------
// mmio_uart_tx
//   Memory-mapped 8N1 UART transmitter on the core's data-memory bus.
//   Stores to TXDATA queue a byte in a small FIFO. A transmit FSM drains the
//   FIFO and serialises each byte LSB-first on tx. STATUS is read
//   combinationally, so a single-cycle core sees it in the same cycle as the
//   load.
//
//   Register window (decode on addr[31:2] only):
//     BASE_ADDR+0  TXDATA  W: push wdata[7:0] (dropped + overflow if full)
//                          R: 0
//     BASE_ADDR+4  STATUS  R: [0] busy [1] full [2] empty [3] overflow
//                             [15:8] FIFO count
//                          W: clear overflow (data ignored)
//
// Ports:
//   clock      in   system clock, rising edge
//   reset      in   synchronous active-low reset
//   addr       in   [31:0] data address
//   wdata      in   [31:0] store data (lane-adjusted)
//   mem_store  in   store strobe, one cycle per store
//   mem_load   in   load strobe
//   sel        out  addr hits TXDATA or STATUS (strobe independent)
//   rdata      out  [31:0] combinational read data
//   tx         out  serial output, idles high
// ---------------------------------------------------------------------------
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
  parameter int          DEPTH        = 8,
  parameter int          CLKS_PER_BIT = 868
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_store,
  input  logic        mem_load,
  output logic        sel,
  output logic [31:0] rdata,
  output logic        tx
);

  localparam int AW = $clog2(DEPTH);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [BW-1:0] BAUD_LAST   = BW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   CNT_FULL    = (AW+1)'(DEPTH);
  localparam logic [31:0]   STATUS_ADDR = BASE_ADDR + 32'd4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // -------------------------------------------------------------------------
  // Address decode and bus strobes
  // -------------------------------------------------------------------------
  logic w_hit_tx, w_hit_st;
  logic w_store_tx, w_store_st;

  assign w_hit_tx   = (addr[31:2] == BASE_ADDR[31:2]);
  assign w_hit_st   = (addr[31:2] == STATUS_ADDR[31:2]);
  assign sel        = w_hit_tx | w_hit_st;
  assign w_store_tx = mem_store & w_hit_tx;
  assign w_store_st = mem_store & w_hit_st;

  // Byte lane bits and upper store data have no meaning in this block.
  logic w_unused;
  assign w_unused = &{1'b0, addr[1:0], wdata[31:8]};

  // -------------------------------------------------------------------------
  // FIFO
  // -------------------------------------------------------------------------
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_ovf;

  state_t        r_state;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_tx;

  logic w_full, w_empty, w_push, w_pop, w_baud_done, w_busy;

  assign w_full      = (r_count == CNT_FULL);
  assign w_empty     = (r_count == '0);
  // Fullness is taken from pre-edge state: a same-cycle pop never makes room.
  assign w_push      = w_store_tx & ~w_full;
  assign w_pop       = (r_state == S_IDLE) & ~w_empty;
  assign w_baud_done = (r_baud == BAUD_LAST);
  assign w_busy      = (r_state != S_IDLE);

  // Storage is deliberately not reset; only valid entries are ever read.
  always_ff @(posedge clock) begin
    if (reset && w_push) r_mem[r_wr_ptr] <= wdata[7:0];
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_store_tx && w_full) r_ovf <= 1'b1;
      else if (w_store_st)      r_ovf <= 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Transmit FSM. tx is registered: the value for the next bit period is
  // loaded on the edge that enters it, so the pop cycle in IDLE already
  // schedules the start bit for the following cycle.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx   <= 1'b1;
          r_baud <= '0;
          r_bit  <= '0;
          if (w_pop) begin
            r_shift <= r_mem[r_rd_ptr];
            r_state <= S_START;
            r_tx    <= 1'b0;
          end
        end
        S_START: begin
          if (w_baud_done) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_state <= S_DATA;
            r_tx    <= r_shift[0];
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
        S_DATA: begin
          if (w_baud_done) begin
            r_baud  <= '0;
            r_shift <= {1'b0, r_shift[7:1]};
            if (r_bit == 3'd7) begin
              r_state <= S_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_bit <= r_bit + 3'd1;
              // Next bit is the one that the shift above brings into [0].
              r_tx  <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
        S_STOP: begin
          r_tx <= 1'b1;
          if (w_baud_done) begin
            r_baud  <= '0;
            r_state <= S_IDLE;
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

  assign tx = r_tx;

  // -------------------------------------------------------------------------
  // Combinational read path. The count field is 8 bits wide; at DEPTH=256 a
  // full FIFO reads count 0 there, and the full bit disambiguates.
  // -------------------------------------------------------------------------
  always_comb begin
    rdata = '0;
    if (mem_load && w_hit_st) begin
      rdata[0]    = w_busy;
      rdata[1]    = w_full;
      rdata[2]    = w_empty;
      rdata[3]    = r_ovf;
      rdata[15:8] = 8'(r_count);
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_mmio_uart_tx
//   Drives bus stores/loads against mmio_uart_tx (DEPTH=8, CLKS_PER_BIT=4).
//   Every accepted byte is pushed to sb_q when its store is driven; a tx
//   monitor captures each frame cycle by cycle, pops the head of sb_q and
//   compares the whole 10-bit-period waveform.
// ---------------------------------------------------------------------------
module tb_mmio_uart_tx;
  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam logic [31:0] TXD  = BASE;
  localparam logic [31:0] STA  = BASE + 32'd4;
  localparam int CPB  = 4;
  localparam int DEP  = 8;
  localparam int FLEN = 10 * CPB;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic        mem_store = 1'b0, mem_load = 1'b0;
  logic        sel, tx;
  logic [31:0] rdata;

  always #5 clock = ~clock;

  mmio_uart_tx #(.BASE_ADDR(BASE), .DEPTH(DEP), .CLKS_PER_BIT(CPB)) dut (
    .clock(clock), .reset(reset), .addr(addr), .wdata(wdata),
    .mem_store(mem_store), .mem_load(mem_load),
    .sel(sel), .rdata(rdata), .tx(tx)
  );

  int n_chk = 0, n_pass = 0;
  logic [7:0] sb_q[$];
  int start_q[$];
  int frames_started = 0, frames_done = 0;
  int cyc_cnt = 0;

  always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [FLEN-1:0] frame_bits(input logic [7:0] b);
    logic [FLEN-1:0] w;
    w = '0;
    for (int k = 0; k < 8; k++)
      for (int j = 0; j < CPB; j++) w[CPB*(k+1)+j] = b[k];
    for (int j = 0; j < CPB; j++) w[CPB*9+j] = 1'b1;
    return w;
  endfunction

  // tx monitor: samples on the falling edge, frame cycle 0 = first start cycle
  initial begin
    logic            act;
    int              mcyc;
    logic [FLEN-1:0] obs;
    logic [7:0]      eb;
    act = 1'b0; mcyc = 0; obs = '0;
    forever begin
      @(negedge clock);
      if (reset !== 1'b1) begin
        act = 1'b0;
      end else if (!act) begin
        if (tx === 1'b0) begin
          act = 1'b1; mcyc = 0; obs = '0; obs[0] = tx;
          start_q.push_back(cyc_cnt);
          frames_started++;
        end
      end else begin
        mcyc++;
        obs[mcyc] = tx;
        if (mcyc == FLEN - 1) begin
          act = 1'b0;
          check("frame_expected", sb_q.size() > 0, 1);
          if (sb_q.size() > 0) begin
            eb = sb_q.pop_front();
            check("frame", obs, frame_bits(eb));
          end
          frames_done++;
        end
      end
    end
  end

  task automatic do_store(input logic [31:0] a, input logic [31:0] d);
    @(posedge clock); #1;
    addr = a; wdata = d; mem_store = 1'b1; mem_load = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a, output logic [31:0] rd, output logic s);
    @(posedge clock); #1;
    addr = a; mem_store = 1'b0; mem_load = 1'b1;
    #2; rd = rdata; s = sel;
  endtask

  task automatic do_ldst(input logic [31:0] a, input logic [31:0] d, output logic [31:0] rd);
    @(posedge clock); #1;
    addr = a; wdata = d; mem_store = 1'b1; mem_load = 1'b1;
    #2; rd = rdata;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock); #1;
      mem_store = 1'b0; mem_load = 1'b0;
    end
  endtask

  task automatic wait_done(input int n, input int budget, input string tag);
    int t;
    t = 0;
    while (frames_done < n && t < budget) begin
      @(posedge clock); t++;
    end
    check(tag, frames_done >= n, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        s, ok;
    int          k, base, t;
    logic [7:0]  d;

    // ---- reset / idle ----
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    check("rst_tx", tx, 1);
    do_load(STA, rd, s);
    check("rst_status", rd, 32'h0000_0004);
    check("rst_sel", s, 1);
    do_load(BASE + 32'd8, rd, s);
    check("miss_sel", s, 0);
    check("miss_rdata", rd, 0);
    do_load(BASE + 32'd6, rd, s);
    check("status_lowbits", rd, 32'h0000_0004);
    do_load(TXD, rd, s);
    check("txdata_read", rd, 0);
    check("txdata_sel", s, 1);
    @(posedge clock); #1;
    mem_load = 1'b0; addr = STA;
    #2;
    check("sel_nostrobe", sel, 1);
    check("rdata_noload", rdata, 0);

    // ---- single byte ----
    do_store(TXD, 32'h0000_00A5);
    sb_q.push_back(8'hA5);
    k = cyc_cnt;
    do_load(STA, rd, s);
    check("pop_cycle_status", rd, 32'h0000_0100);
    ok = 1'b1;
    for (int i = 0; i < FLEN; i++) begin
      do_load(STA, rd, s);
      if (rd !== 32'h0000_0005) ok = 1'b0;
    end
    check("busy_frame", ok, 1);
    do_load(STA, rd, s);
    check("post_frame_status", rd, 32'h0000_0004);
    wait_done(1, 100, "single_done");
    check("first_start", start_q[0], k + 2);

    // ---- back-to-back ----
    idle(2);
    base = frames_started;
    do_store(TXD, 32'h0000_0055); sb_q.push_back(8'h55);
    do_store(TXD, 32'h0000_000F); sb_q.push_back(8'h0F);
    idle(3);
    do_load(STA, rd, s);
    check("b2b_count", rd, 32'h0000_0101);
    wait_done(frames_done + 2, 3 * (FLEN + 1), "b2b_done");
    check("b2b_gap", start_q[base+1] - start_q[base], FLEN + 1);

    // ---- full / overflow ----
    idle(2);
    k = frames_done;
    for (int i = 1; i <= 10; i++) begin
      do_store(TXD, 32'(i));
      if (i <= 9) sb_q.push_back(8'(i));
    end
    do_load(STA, rd, s);
    check("full_status", rd, 32'h0000_080B);
    do_ldst(STA, 32'hFFFF_FFFF, rd);
    check("ldst_preedge", rd, 32'h0000_080B);
    do_load(STA, rd, s);
    check("ovf_cleared", rd, 32'h0000_0803);
    wait_done(k + 9, 9 * (FLEN + 1) + 100, "ovf_done");
    idle(2);
    do_load(STA, rd, s);
    check("ovf_drained", rd, 32'h0000_0004);

    // ---- pointer wrap-around ----
    k = frames_done;
    for (int i = 0; i < 20; i++) begin
      d = 8'($urandom_range(0, 255));
      do_store(TXD, {24'h0, d});
      sb_q.push_back(d);
      idle(30);
    end
    wait_done(k + 20, 20 * (FLEN + 1), "wrap_done");
    idle(2);
    do_load(STA, rd, s);
    check("wrap_status", rd, 32'h0000_0004);
    check("wrap_sb_empty", sb_q.size(), 0);

    // ---- reset mid-frame ----
    base = frames_started;
    for (int i = 0; i < 4; i++) begin
      do_store(TXD, 32'hC0 + 32'(i));
      sb_q.push_back(8'hC0 + 8'(i));
    end
    idle(1);
    t = 0;
    while (frames_started == base && t < 50) begin
      @(posedge clock); t++;
    end
    check("midrst_started", frames_started > base, 1);
    do_load(STA, rd, s);
    check("midrst_queued", rd, 32'h0000_0301);
    repeat (15) @(posedge clock);
    #1 reset = 1'b0; mem_load = 1'b0;
    @(posedge clock); #1;
    check("midrst_tx", tx, 1);
    sb_q.delete();
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    do_load(STA, rd, s);
    check("midrst_status", rd, 32'h0000_0004);
    base = frames_started;
    idle(100);
    check("midrst_no_frames", frames_started, base);
    check("midrst_tx_idle", tx, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
